// File: rtl/acc_ctrl_pkg.sv
// acc_ctrl_pkg: shared types and constants for the accumulator write controller
package acc_ctrl_pkg;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {ACC_CLEAR, ACC_LOAD_REG, ACC_LOAD_ALU, ACC_LOAD_IMM8} acc_op_t;
  typedef enum logic [1:0] {IDLE, ONE, IMM_A, IMM_B} ctrl_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  // count up on inc, hold once every bit is set
  always_ff @(posedge clk or negedge Reset_n)
    if (!Reset_n) count <= '0;
    else if (clear) count <= '0;
    else if (inc && !(&count)) count <= count + CNT_W'(1);
endmodule

// File: rtl/acc_write_ctrl.sv
// acc_write_ctrl: sequences accumulator write strobes from a decoder valid/ready stream
module acc_write_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int W        = 8,
  parameter int HI_FIRST = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [W-1:0]     req_imm,
  output logic             req_ready,
  input  logic             Stall,
  output logic             Write_En,
  output logic             From_Reg,
  output logic             From_ALU,
  output logic             From_Imm,
  output logic             Load_Hi,
  output logic [NIB_W-1:0] Imm_out,
  output logic             op_done,
  output logic [CNT_W-1:0] wr_count
);
  ctrl_state_t state_q, state_d, new_st;
  acc_op_t     op_q;
  logic [W-1:0] imm_q;
  logic accept, in_imm, hi_beat;
  // handshake, strobe decode and next state, all from the registered state
  always_comb begin
    req_ready = Reset_n && (state_q == IDLE || ((state_q == ONE || state_q == IMM_B) && !Stall));
    accept    = req_valid && req_ready;
    Write_En  = state_q != IDLE && !Stall;
    in_imm    = state_q == IMM_A || state_q == IMM_B;
    hi_beat   = in_imm && ((state_q == IMM_A) == (HI_FIRST != 0));
    From_Reg  = state_q == ONE && op_q == ACC_LOAD_REG;
    From_ALU  = state_q == ONE && op_q == ACC_LOAD_ALU;
    From_Imm  = in_imm;
    Load_Hi   = hi_beat;
    Imm_out   = !in_imm ? '0 : hi_beat ? imm_q[W-1 -: NIB_W] : imm_q[NIB_W-1:0];
    op_done   = Write_En && (state_q == ONE || state_q == IMM_B);
    new_st    = acc_op_t'(req_op) == ACC_LOAD_IMM8 ? IMM_A : ONE;
    state_d   = state_q == IMM_A ? (Stall ? IMM_A : IMM_B) :
                accept ? new_st :
                (state_q == IDLE || !Stall) ? IDLE : state_q;
  end
  // state register and capture of the accepted request
  always_ff @(posedge clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= IDLE;
      op_q    <= ACC_CLEAR;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= acc_op_t'(req_op);
        imm_q <= req_imm;
      end
    end
  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .Reset_n (Reset_n),
    .clear   (1'b0),
    .inc     (Write_En),
    .count   (wr_count)
  );
  // a request that is held waiting must not change under the controller
  assert property (@(posedge clk) disable iff (!Reset_n)
    (req_valid && !req_ready) |=> (!req_valid || ($stable(req_op) && $stable(req_imm))))
    else $error("request changed while waiting for req_ready");
endmodule
